// File: rtl/pc_sequencer.sv
// Program-counter stage with fetch handshake and a circular return-address stack.
// Define PCSEQ_STACK_ERR_EN to add the sticky o_stack_err overflow/underflow flag.
module pc_sequencer #(
  parameter logic [15:0] RESET_VEC = 16'h0000,
  parameter int          DEPTH     = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_stall,
  input  logic                         i_fetch_ready,
  input  logic                         i_jmp,
  input  logic                         i_call,
  input  logic                         i_ret,
  input  logic [15:0]                  i_target,
  output logic [15:0]                  o_pc,
  output logic                         o_fetch_valid,
  output logic [$clog2(DEPTH+1)-1:0]   o_depth
`ifdef PCSEQ_STACK_ERR_EN
  ,
  output logic                         o_stack_err
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int DW = $clog2(DEPTH+1);
  localparam logic [PW-1:0] TOP_MAX = PW'(DEPTH-1);
  localparam logic [DW-1:0] D_FULL  = DW'(DEPTH);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   pc_q, pc_d;
  logic [PW-1:0] top_q, top_d;
  logic [DW-1:0] depth_q, depth_d;
  logic [15:0]   stk_q [DEPTH];

  logic          redir_ok;
  logic          pop, push, jump, adv;
  logic          full, empty;
  logic [PW-1:0] top_inc, top_dec;
  logic [15:0]   pc_inc;

  // top_q points at the next free slot; top_q-1 is the most recent push
  always_comb begin
    top_inc  = (top_q == TOP_MAX) ? '0 : top_q + 1'b1;
    top_dec  = (top_q == '0) ? TOP_MAX : top_q - 1'b1;
    pc_inc   = pc_q + 16'd1;
    full     = (depth_q == D_FULL);
    empty    = (depth_q == '0);
    redir_ok = (state_q != BOOT);
    pop      = redir_ok & i_ret;
    push     = redir_ok & i_call & ~i_ret;
    jump     = redir_ok & i_jmp & ~i_call & ~i_ret;
    adv      = (state_q == FETCH) & i_fetch_ready
             & ~pop & ~push & ~jump;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = FETCH;
      FETCH:   state_d = i_stall ? HOLD : FETCH;
      HOLD:    state_d = i_stall ? HOLD : FETCH;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    unique case (1'b1)
      pop:     pc_d = empty ? RESET_VEC : stk_q[top_dec];
      push:    pc_d = i_target;
      jump:    pc_d = i_target;
      adv:     pc_d = pc_inc;
      default: pc_d = pc_q;
    endcase
  end

  // A push when full overwrites the oldest entry, which sits at top_q
  always_comb begin
    top_d   = top_q;
    depth_d = depth_q;
    if (push) begin
      top_d   = top_inc;
      depth_d = full ? depth_q : depth_q + 1'b1;
    end else if (pop && !empty) begin
      top_d   = top_dec;
      depth_d = depth_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
      top_q   <= '0;
      depth_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      top_q   <= top_d;
      depth_q <= depth_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      stk_q[top_q] <= pc_inc;
    end
  end

`ifdef PCSEQ_STACK_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (push & full) | (pop & empty);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign o_stack_err = err_q;
`endif

  assign o_pc          = pc_q;
  assign o_fetch_valid = (state_q == FETCH);
  assign o_depth       = depth_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (RESET_VEC=0x0100, DEPTH=4).
// Observed tuple is {o_fetch_valid, o_pc, o_depth}.
module tb_pc_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_fetch_ready = 1'b0;
  logic        i_jmp = 1'b0;
  logic        i_call = 1'b0;
  logic        i_ret = 1'b0;
  logic [15:0] i_target = 16'h0;
  logic [15:0] o_pc;
  logic        o_fetch_valid;
  logic [2:0]  o_depth;
`ifdef PCSEQ_STACK_ERR_EN
  logic        o_stack_err;
`endif

  int checks = 0;
  int failures = 0;

  pc_sequencer #(
    .RESET_VEC(16'h0100),
    .DEPTH(4)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_stall(i_stall),
    .i_fetch_ready(i_fetch_ready),
    .i_jmp(i_jmp),
    .i_call(i_call),
    .i_ret(i_ret),
    .i_target(i_target),
    .o_pc(o_pc),
    .o_fetch_valid(o_fetch_valid),
    .o_depth(o_depth)
`ifdef PCSEQ_STACK_ERR_EN
    ,
    .o_stack_err(o_stack_err)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    logic [19:0] exp;
    i_rst_n = 1'b0;
    i_fetch_ready = 1'b1;
    i_jmp = 1'b1;
    i_target = 16'h0ABC;
    tick();
    tick();
    exp = {1'b0, 16'h0100, 3'd0};
    checks++;
    if ({o_fetch_valid, o_pc, o_depth} !== exp) begin
      failures++;
      $display("FAIL reset got=%h exp=%h", {o_fetch_valid, o_pc, o_depth}, exp);
    end
    i_rst_n = 1'b1;
    tick();
    exp = {1'b1, 16'h0100, 3'd0};
    checks++;
    if ({o_fetch_valid, o_pc, o_depth} !== exp) begin
      failures++;
      $display("FAIL boot_exit got=%h exp=%h", {o_fetch_valid, o_pc, o_depth}, exp);
    end
    i_jmp = 1'b0;
    tick();
    checks++;
    if (o_pc !== 16'h0101) begin
      failures++;
      $display("FAIL adv1 got=%h exp=0101", o_pc);
    end
    tick();
    checks++;
    if (o_pc !== 16'h0102) begin
      failures++;
      $display("FAIL adv2 got=%h exp=0102", o_pc);
    end
  endtask

  task automatic test_wrap();
    i_jmp = 1'b1;
    i_target = 16'hFFFF;
    tick();
    checks++;
    if (o_pc !== 16'hFFFF) begin
      failures++;
      $display("FAIL jmp_ffff got=%h exp=ffff", o_pc);
    end
    i_jmp = 1'b0;
    tick();
    checks++;
    if ({o_fetch_valid, o_pc} !== {1'b1, 16'h0000}) begin
      failures++;
      $display("FAIL wrap got=%h exp=10000", {o_fetch_valid, o_pc});
    end
  endtask

  task automatic test_ready_stall();
    i_fetch_ready = 1'b0;
    i_jmp = 1'b1;
    i_target = 16'h0010;
    tick();
    i_jmp = 1'b0;
    checks++;
    if (o_pc !== 16'h0010) begin
      failures++;
      $display("FAIL jmp_0010 got=%h exp=0010", o_pc);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({o_fetch_valid, o_pc} !== {1'b1, 16'h0010}) begin
        failures++;
        $display("FAIL not_ready%0d got=%h exp=10010", i, {o_fetch_valid, o_pc});
      end
    end
    i_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({o_fetch_valid, o_pc} !== {1'b0, 16'h0010}) begin
        failures++;
        $display("FAIL stall%0d got=%h exp=00010", i, {o_fetch_valid, o_pc});
      end
    end
    i_stall = 1'b0;
    tick();
    checks++;
    if ({o_fetch_valid, o_pc} !== {1'b1, 16'h0010}) begin
      failures++;
      $display("FAIL unstall got=%h exp=10010", {o_fetch_valid, o_pc});
    end
  endtask

  task automatic test_stall_advance();
    i_fetch_ready = 1'b1;
    i_stall = 1'b1;
    tick();
    checks++;
    if ({o_fetch_valid, o_pc} !== {1'b0, 16'h0011}) begin
      failures++;
      $display("FAIL stall_adv got=%h exp=00011", {o_fetch_valid, o_pc});
    end
    tick();
    checks++;
    if ({o_fetch_valid, o_pc} !== {1'b0, 16'h0011}) begin
      failures++;
      $display("FAIL hold_no_adv got=%h exp=00011", {o_fetch_valid, o_pc});
    end
    i_jmp = 1'b1;
    i_target = 16'h0200;
    tick();
    checks++;
    if ({o_fetch_valid, o_pc} !== {1'b0, 16'h0200}) begin
      failures++;
      $display("FAIL hold_jmp got=%h exp=00200", {o_fetch_valid, o_pc});
    end
    i_jmp = 1'b0;
    i_stall = 1'b0;
    i_fetch_ready = 1'b0;
    tick();
    checks++;
    if ({o_fetch_valid, o_pc} !== {1'b1, 16'h0200}) begin
      failures++;
      $display("FAIL hold_exit got=%h exp=10200", {o_fetch_valid, o_pc});
    end
  endtask

  task automatic test_nested_calls();
    logic [19:0] exp;
    i_jmp = 1'b1;
    i_target = 16'h0020;
    tick();
    i_jmp = 1'b0;
    i_call = 1'b1;
    i_fetch_ready = 1'b1;
    i_target = 16'h0300;
    tick();
    exp = {1'b1, 16'h0300, 3'd1};
    checks++;
    if ({o_fetch_valid, o_pc, o_depth} !== exp) begin
      failures++;
      $display("FAIL call1 got=%h exp=%h", {o_fetch_valid, o_pc, o_depth}, exp);
    end
    i_fetch_ready = 1'b0;
    i_call = 1'b0;
    i_jmp = 1'b1;
    i_target = 16'h0305;
    tick();
    i_jmp = 1'b0;
    i_call = 1'b1;
    i_target = 16'h0400;
    tick();
    exp = {1'b1, 16'h0400, 3'd2};
    checks++;
    if ({o_fetch_valid, o_pc, o_depth} !== exp) begin
      failures++;
      $display("FAIL call2 got=%h exp=%h", {o_fetch_valid, o_pc, o_depth}, exp);
    end
    i_call = 1'b0;
    i_ret = 1'b1;
    tick();
    exp = {1'b1, 16'h0306, 3'd1};
    checks++;
    if ({o_fetch_valid, o_pc, o_depth} !== exp) begin
      failures++;
      $display("FAIL ret1 got=%h exp=%h", {o_fetch_valid, o_pc, o_depth}, exp);
    end
    tick();
    exp = {1'b1, 16'h0021, 3'd0};
    checks++;
    if ({o_fetch_valid, o_pc, o_depth} !== exp) begin
      failures++;
      $display("FAIL ret2 got=%h exp=%h", {o_fetch_valid, o_pc, o_depth}, exp);
    end
    i_ret = 1'b0;
  endtask

  task automatic test_priority();
    logic [19:0] exp;
    i_jmp = 1'b1;
    i_target = 16'h0041;
    tick();
    i_jmp = 1'b0;
    i_call = 1'b1;
    i_target = 16'h0500;
    tick();
    exp = {1'b1, 16'h0500, 3'd1};
    checks++;
    if ({o_fetch_valid, o_pc, o_depth} !== exp) begin
      failures++;
      $display("FAIL prio_setup got=%h exp=%h", {o_fetch_valid, o_pc, o_depth}, exp);
    end
    i_ret = 1'b1;
    i_jmp = 1'b1;
    i_target = 16'h0777;
    tick();
    exp = {1'b1, 16'h0042, 3'd0};
    checks++;
    if ({o_fetch_valid, o_pc, o_depth} !== exp) begin
      failures++;
      $display("FAIL prio_ret got=%h exp=%h", {o_fetch_valid, o_pc, o_depth}, exp);
    end
    i_ret = 1'b0;
    i_call = 1'b0;
    i_jmp = 1'b0;
  endtask

  task automatic test_overflow();
    logic [15:0] tgt [5];
    logic [15:0] rets [4];
    logic [19:0] exp;
    tgt  = '{16'h2000, 16'h3000, 16'h4000, 16'h5000, 16'h6000};
    rets = '{16'h5001, 16'h4001, 16'h3001, 16'h2001};
    i_jmp = 1'b1;
    i_target = 16'h1000;
    tick();
    i_jmp = 1'b0;
    i_call = 1'b1;
    for (int i = 0; i < 5; i++) begin
      i_target = tgt[i];
      tick();
      exp = {1'b1, tgt[i], (i < 4) ? 3'(i + 1) : 3'd4};
      checks++;
      if ({o_fetch_valid, o_pc, o_depth} !== exp) begin
        failures++;
        $display("FAIL ovf_call%0d got=%h exp=%h", i, {o_fetch_valid, o_pc, o_depth}, exp);
      end
`ifdef PCSEQ_STACK_ERR_EN
      checks++;
      if (o_stack_err !== (i == 4)) begin
        failures++;
        $display("FAIL err_call%0d got=%b exp=%b", i, o_stack_err, (i == 4));
      end
`endif
    end
    i_call = 1'b0;
    i_ret = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp = {1'b1, rets[i], 3'(3 - i)};
      checks++;
      if ({o_fetch_valid, o_pc, o_depth} !== exp) begin
        failures++;
        $display("FAIL ovf_ret%0d got=%h exp=%h", i, {o_fetch_valid, o_pc, o_depth}, exp);
      end
    end
    tick();
    exp = {1'b1, 16'h0100, 3'd0};
    checks++;
    if ({o_fetch_valid, o_pc, o_depth} !== exp) begin
      failures++;
      $display("FAIL underflow got=%h exp=%h", {o_fetch_valid, o_pc, o_depth}, exp);
    end
`ifdef PCSEQ_STACK_ERR_EN
    checks++;
    if (o_stack_err !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky got=%b exp=1", o_stack_err);
    end
`endif
    i_ret = 1'b0;
    i_rst_n = 1'b0;
    tick();
    exp = {1'b0, 16'h0100, 3'd0};
    checks++;
    if ({o_fetch_valid, o_pc, o_depth} !== exp) begin
      failures++;
      $display("FAIL rereset got=%h exp=%h", {o_fetch_valid, o_pc, o_depth}, exp);
    end
`ifdef PCSEQ_STACK_ERR_EN
    checks++;
    if (o_stack_err !== 1'b0) begin
      failures++;
      $display("FAIL err_reset got=%b exp=0", o_stack_err);
    end
`endif
    i_rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_ready_stall();
    test_stall_advance();
    test_nested_calls();
    test_priority();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
